// File: rtl/async_fifo_lvl.sv
`timescale 1ns/1ps
// async_fifo_lvl: dual-clock FIFO with Gray-coded pointer crossing, per-domain
// fill levels, almost-full/almost-empty flags, overflow/underflow pulses and an
// optional first-word-fall-through read port.
//
// Ports
//   rst                      async active-high reset for both domains
//   wr_clk, wr_en, din       write port
//   full, almost_full        write-side flags (registered, wr_clk)
//   wr_count                 pessimistic fill level seen by the writer
//   overflow                 one-cycle pulse on wr_en while full
//   rd_clk, rd_en            read port (rd_en pops when FWFT=1)
//   dout, valid              read data and its qualifier (registered, rd_clk)
//   empty, almost_empty      read-side flags (registered, rd_clk)
//   rd_count                 pessimistic fill level seen by the reader
//   underflow                one-cycle pulse on rd_en while empty
module async_fifo_lvl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_TH    = 28,
  parameter int unsigned AEMPTY_TH   = 4,
  parameter int unsigned FWFT        = 0
) (
  input  logic             rst,
  input  logic             wr_clk,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  output logic [DEPTH:0]   wr_count,
  output logic             overflow,
  input  logic             rd_clk,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [DEPTH:0]   rd_count,
  output logic             underflow
);

  localparam int unsigned PW      = DEPTH + 1;
  localparam int unsigned ENTRIES = 1 << DEPTH;
  localparam logic [PW-1:0] ENTRIES_V = PW'(ENTRIES);
  localparam logic [PW-1:0] AFULL_V   = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_V  = PW'(AEMPTY_TH);
  localparam bit            FWFT_EN   = (FWFT != 0);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] mem [ENTRIES];

  // Local resets: asserted asynchronously with rst, released on the local clock.
  logic [1:0] wr_rst_q, rd_rst_q;
  logic       wr_rst, rd_rst;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) wr_rst_q <= 2'b11;
    else     wr_rst_q <= {wr_rst_q[0], 1'b0};
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) rd_rst_q <= 2'b11;
    else     rd_rst_q <= {rd_rst_q[0], 1'b0};
  end

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  // ---------------------------------------------------------------- write side
  logic [PW-1:0] wptr_bin, wptr_gray;
  logic [PW-1:0] rptr_gray;
  logic [PW-1:0] rq_sync [SYNC_STAGES];
  logic          wr_fire;
  logic [PW-1:0] wptr_bin_nxt, wr_count_nxt;

  // Read pointer into the write domain.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) rq_sync[i] <= '0;
    end else begin
      rq_sync[0] <= rptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) rq_sync[i] <= rq_sync[i-1];
    end
  end

  // Count is taken against the next write pointer so full tracks the write edge.
  always_comb begin
    wr_fire      = wr_en && !full && !wr_rst;
    wptr_bin_nxt = wptr_bin + PW'(wr_fire);
    wr_count_nxt = wptr_bin_nxt - gray2bin(rq_sync[SYNC_STAGES-1]);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      wr_count    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wptr_bin    <= wptr_bin_nxt;
      wptr_gray   <= bin2gray(wptr_bin_nxt);
      wr_count    <= wr_count_nxt;
      full        <= (wr_count_nxt == ENTRIES_V);
      almost_full <= (wr_count_nxt >= AFULL_V);
      overflow    <= wr_en && full;
    end
  end

  // Storage array, no reset.
  always_ff @(posedge wr_clk) begin
    if (wr_fire) mem[wptr_bin[DEPTH-1:0]] <= din;
  end

  // ----------------------------------------------------------------- read side
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] wq_sync [SYNC_STAGES];
  logic [PW-1:0] wptr_sync_bin, rptr_bin_nxt, rd_count_nxt, rd_addr;
  logic          rd_pop, valid_nxt, load_dout, empty_nxt;

  // Write pointer into the read domain.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) wq_sync[i] <= '0;
    end else begin
      wq_sync[0] <= wptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) wq_sync[i] <= wq_sync[i-1];
    end
  end

  // rptr_bin counts popped words, so in FWFT mode the word held in dout still
  // occupies its slot and is included in rd_count.
  always_comb begin
    wptr_sync_bin = gray2bin(wq_sync[SYNC_STAGES-1]);
    rd_pop        = 1'b0;
    valid_nxt     = 1'b0;
    load_dout     = 1'b0;
    rd_addr       = rptr_bin;
    if (FWFT_EN) begin
      rd_pop       = rd_en && valid && !rd_rst;
      rptr_bin_nxt = rptr_bin + PW'(rd_pop);
      rd_count_nxt = wptr_sync_bin - rptr_bin_nxt;
      valid_nxt    = (rd_count_nxt != '0);
      load_dout    = valid_nxt && (rd_pop || !valid);
      rd_addr      = rptr_bin_nxt;
      empty_nxt    = !valid_nxt;
    end else begin
      rd_pop       = rd_en && !empty && !rd_rst;
      rptr_bin_nxt = rptr_bin + PW'(rd_pop);
      rd_count_nxt = wptr_sync_bin - rptr_bin_nxt;
      valid_nxt    = rd_pop;
      load_dout    = rd_pop;
      empty_nxt    = (rd_count_nxt == '0);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rptr_bin     <= '0;
      rptr_gray    <= '0;
      dout         <= '0;
      valid        <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rptr_bin     <= rptr_bin_nxt;
      rptr_gray    <= bin2gray(rptr_bin_nxt);
      valid        <= valid_nxt;
      empty        <= empty_nxt;
      almost_empty <= (rd_count_nxt <= AEMPTY_V);
      rd_count     <= rd_count_nxt;
      underflow    <= rd_en && empty;
      if (load_dout) dout <= mem[rd_addr[DEPTH-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo_lvl.sv
`timescale 1ns/1ps
// Scoreboard bench for async_fifo_lvl: registered-read instance for the main
// scenarios plus an FWFT instance for the fall-through check.
module tb_async_fifo_lvl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned SS    = 2;

  logic rst, wr_clk, rd_clk;

  logic             wr_en, rd_en;
  logic [WIDTH-1:0] din, dout;
  logic             full, almost_full, overflow;
  logic             valid, empty, almost_empty, underflow;
  logic [DEPTH:0]   wr_count, rd_count;

  logic             f_wr_en, f_rd_en;
  logic [WIDTH-1:0] f_din, f_dout;
  logic             f_full, f_almost_full, f_overflow;
  logic             f_valid, f_empty, f_almost_empty, f_underflow;
  logic [DEPTH:0]   f_wr_count, f_rd_count;

  async_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS),
                   .AFULL_TH(28), .AEMPTY_TH(4), .FWFT(0)) u_dut (
    .rst(rst), .wr_clk(wr_clk), .wr_en(wr_en), .din(din), .full(full),
    .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow),
    .rd_clk(rd_clk), .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .underflow(underflow));

  async_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS),
                   .AFULL_TH(28), .AEMPTY_TH(4), .FWFT(1)) u_dut_fwft (
    .rst(rst), .wr_clk(wr_clk), .wr_en(f_wr_en), .din(f_din), .full(f_full),
    .almost_full(f_almost_full), .wr_count(f_wr_count), .overflow(f_overflow),
    .rd_clk(rd_clk), .rd_en(f_rd_en), .dout(f_dout), .valid(f_valid), .empty(f_empty),
    .almost_empty(f_almost_empty), .rd_count(f_rd_count), .underflow(f_underflow));

  real wr_half = 5.0;
  real rd_half = 4.0;

  initial begin
    wr_clk = 1'b0;
    forever #(wr_half) wr_clk = ~wr_clk;
  end

  initial begin
    rd_clk = 1'b0;
    forever #(rd_half) rd_clk = ~rd_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_rx     = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Every valid word from the registered-read instance must match the scoreboard head.
  always @(negedge rd_clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underrun", 32'(sb.size()), 32'd1);
      end else begin
        chk("rd_data", 32'(dout), 32'(sb.pop_front()));
        n_rx++;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_full"},         32'(full),         32'd0);
    chk({tag, "_almost_full"},  32'(almost_full),  32'd0);
    chk({tag, "_wr_count"},     32'(wr_count),     32'd0);
    chk({tag, "_overflow"},     32'(overflow),     32'd0);
    chk({tag, "_dout"},         32'(dout),         32'd0);
    chk({tag, "_valid"},        32'(valid),        32'd0);
    chk({tag, "_empty"},        32'(empty),        32'd1);
    chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_rd_count"},     32'(rd_count),     32'd0);
    chk({tag, "_underflow"},    32'(underflow),    32'd0);
  endtask

  // Free-running producer/consumer; producer respects full, consumer respects empty.
  task automatic run_stream(input int n_words, input int seq0);
    int target;
    target = n_rx + n_words;
    fork
      begin : producer
        int n, c;
        n = 0;
        c = 0;
        while (n < n_words && c < 20000) begin
          @(negedge wr_clk);
          c++;
          if (!full) begin
            wr_en = 1'b1;
            din   = WIDTH'(seq0 + n);
            sb.push_back(WIDTH'(seq0 + n));
            n++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin : consumer
        int c;
        c = 0;
        while (n_rx < target && c < 20000) begin
          @(negedge rd_clk);
          rd_en = !empty;
          c++;
        end
        rd_en = 1'b0;
        chk("stream_words", 32'(n_rx), 32'(target));
      end
    join
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    logic [WIDTH-1:0] held;
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge wr_clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge wr_clk);
    repeat (5) @(negedge rd_clk);

    // Burst fill to capacity, no reads.
    for (int i = 0; i < 32; i++) begin
      @(negedge wr_clk);
      wr_en = 1'b1;
      din   = WIDTH'(i);
      sb.push_back(WIDTH'(i));
      @(posedge wr_clk);
      #1;
      chk("fill_wr_count",    32'(wr_count),    32'(i + 1));
      chk("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 28));
      chk("fill_full",        32'(full),        32'(i + 1 == 32));
    end

    // One extra write while full is dropped.
    @(negedge wr_clk);
    din = WIDTH'(32);
    @(posedge wr_clk);
    #1;
    chk("ovf_pulse",    32'(overflow), 32'd1);
    chk("ovf_wr_count", 32'(wr_count), 32'd32);
    chk("ovf_full",     32'(full),     32'd1);
    @(negedge wr_clk);
    wr_en = 1'b0;
    @(posedge wr_clk);
    #1;
    chk("ovf_single", 32'(overflow), 32'd0);

    // Drain all 32, then one read while empty.
    c = 0;
    while (rd_count != (DEPTH+1)'(32) && c < 50) begin
      @(negedge rd_clk);
      c++;
    end
    chk("drain_rd_count_start", 32'(rd_count), 32'd32);
    chk("drain_almost_empty0",  32'(almost_empty), 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge rd_clk);
      rd_en = 1'b1;
    end
    @(negedge rd_clk);
    chk("drain_empty", 32'(empty), 32'd1);
    @(negedge rd_clk);
    rd_en = 1'b0;
    chk("udf_pulse",        32'(underflow),    32'd1);
    chk("udf_rd_count",     32'(rd_count),     32'd0);
    chk("udf_almost_empty", 32'(almost_empty), 32'd1);
    @(negedge rd_clk);
    chk("udf_single", 32'(underflow),  32'd0);
    chk("drain_dout_hold", 32'(dout),  32'd31);
    chk("drain_sb_left", 32'(sb.size()), 32'd0);
    c = 0;
    while ((wr_count != '0 || full) && c < 50) begin
      @(negedge wr_clk);
      c++;
    end
    chk("drain_wr_count", 32'(wr_count), 32'd0);
    chk("drain_full",     32'(full),     32'd0);

    // Streaming at two clock ratios.
    wr_half = 8.0; rd_half = 3.5;
    run_stream(2000, 16'h1000);
    wr_half = 3.5; rd_half = 8.0;
    run_stream(2000, 16'h4000);
    repeat (4) @(negedge rd_clk);
    chk("stream_sb_left", 32'(sb.size()), 32'd0);
    wr_half = 5.0; rd_half = 4.0;
    repeat (4) @(negedge wr_clk);

    // Reset in the middle of traffic.
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      wr_en = 1'b1;
      din   = WIDTH'(16'h0200 + i);
      sb.push_back(WIDTH'(16'h0200 + i));
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
    c = 0;
    while (rd_count < (DEPTH+1)'(3) && c < 50) begin
      @(negedge rd_clk);
      c++;
    end
    repeat (3) begin
      @(negedge rd_clk);
      rd_en = 1'b1;
    end
    @(negedge rd_clk);
    rd_en = 1'b0;
    @(negedge rd_clk);
    chk("mid_sb_left", 32'(sb.size()), 32'd7);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    repeat (3) @(negedge wr_clk);
    rst = 1'b0;
    repeat (5) @(negedge wr_clk);
    repeat (5) @(negedge rd_clk);
    chk_reset_outputs("postrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge wr_clk);
      wr_en = 1'b1;
      din   = WIDTH'(16'h0300 + i);
      sb.push_back(WIDTH'(16'h0300 + i));
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(negedge rd_clk);
      rd_en = !empty;
      c++;
    end
    rd_en = 1'b0;
    chk("postrst_sb_left", 32'(sb.size()), 32'd0);

    // FWFT instance: single word falls through without rd_en.
    @(negedge wr_clk);
    f_wr_en = 1'b1;
    f_din   = 16'hA5A5;
    @(negedge wr_clk);
    f_wr_en = 1'b0;
    c = 0;
    while (!f_valid && c < int'(SS) + 3) begin
      @(negedge rd_clk);
      c++;
    end
    chk("fwft_valid",    32'(f_valid),    32'd1);
    chk("fwft_dout",     32'(f_dout),     32'hA5A5);
    chk("fwft_empty",    32'(f_empty),    32'd0);
    chk("fwft_rd_count", 32'(f_rd_count), 32'd1);
    held = f_dout;
    repeat (2) @(negedge rd_clk);
    chk("fwft_hold_valid", 32'(f_valid), 32'd1);
    chk("fwft_hold_dout",  32'(f_dout),  32'(held));
    @(negedge rd_clk);
    f_rd_en = 1'b1;
    @(negedge rd_clk);
    f_rd_en = 1'b0;
    chk("fwft_pop_valid",     32'(f_valid),     32'd0);
    chk("fwft_pop_empty",     32'(f_empty),     32'd1);
    chk("fwft_pop_rd_count",  32'(f_rd_count),  32'd0);
    chk("fwft_pop_underflow", 32'(f_underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
